// File: rtl/axi_stream_insert_header_wide.sv
// -----------------------------------------------------------------------------
// axi_stream_insert_header_wide
// Prepends a per-packet header of 0..MAX_HDR_BYTES bytes to an AXI-Stream
// payload packet. Header bytes and payload bytes are re-packed into full
// output beats. The output goes through one registered stage. A header count
// of 0 passes the payload through unchanged with one cycle of latency.
//
// Ports
//   clk, rst_n       clock (posedge), asynchronous active-low reset
//   valid_in ..      payload stream in (data_in, keep_in, last_in, ready_in)
//   valid_insert ..  header in (data_insert right-aligned, byte_insert_cnt,
//                    ready_insert)
//   valid_out ..     re-packed stream out (data_out, keep_out, last_out),
//                    with ready_out as backpressure
//   pkt_cnt          number of completed output packets (wrapping)
// -----------------------------------------------------------------------------
module axi_stream_insert_header_wide #(
  parameter int DATA_WD       = 32,
  parameter int DATA_BYTE_WD  = DATA_WD / 8,
  parameter int MAX_HDR_BYTES = 16,
  parameter int HDR_CNT_WD    = $clog2(MAX_HDR_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [DATA_WD-1:0]         data_in,
  input  logic [DATA_BYTE_WD-1:0]    keep_in,
  input  logic                       last_in,
  output logic                       ready_in,
  input  logic                       valid_insert,
  input  logic [8*MAX_HDR_BYTES-1:0] data_insert,
  input  logic [HDR_CNT_WD-1:0]      byte_insert_cnt,
  output logic                       ready_insert,
  output logic                       valid_out,
  output logic [DATA_WD-1:0]         data_out,
  output logic [DATA_BYTE_WD-1:0]    keep_out,
  output logic                       last_out,
  input  logic                       ready_out,
  output logic [31:0]                pkt_cnt
);

  localparam int W   = DATA_BYTE_WD;
  // Header buffer is left-aligned with W spare bytes below it, so a full beat
  // can always be taken from the top. This holds even for short headers.
  localparam int HBW = 8 * (MAX_HDR_BYTES + W);
  localparam int CW  = $clog2(MAX_HDR_BYTES + 2 * W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    TAIL = 2'd3
  } state_t;

  state_t               state_r;
  logic [HBW-1:0]       hdr_r;
  logic [CW-1:0]        hdr_len_r;
  logic [DATA_WD-1:0]   res_r;       // residual bytes, left-aligned, rest zero
  logic [CW-1:0]        res_cnt_r;
  logic                 valid_out_r;
  logic [DATA_WD-1:0]   data_out_r;
  logic [W-1:0]         keep_out_r;
  logic                 last_out_r;
  logic                 ready_insert_r;
  logic [31:0]          pkt_cnt_r;

  logic                 adv_s;
  logic                 hdr_fire_s;
  logic                 beat_fire_s;
  logic                 hdr_step_s;
  logic [CW-1:0]        cnt_clamp_s;
  logic [CW-1:0]        ins_shift_s;
  logic [HBW-1:0]       ins_align_s;
  logic [HBW-1:0]       hsrc_s;
  logic [CW-1:0]        hlen_s;
  logic [HBW-1:0]       hshift_s;
  logic [CW-1:0]        hrem_s;
  logic [DATA_WD-1:0]   hbeat_s;
  logic [DATA_WD-1:0]   pay_s;
  logic [CW-1:0]        k_s;
  logic [CW-1:0]        t_s;
  logic [2*DATA_WD-1:0] comb_s;

  // Number of set bits in a keep vector.
  function automatic logic [CW-1:0] popcount(input logic [W-1:0] k);
    logic [CW-1:0] c;
    c = {CW{1'b0}};
    for (int i = 0; i < W; i++) begin
      c = c + {{(CW-1){1'b0}}, k[i]};
    end
    return c;
  endfunction

  // Keep vector with the top n bits set.
  function automatic logic [W-1:0] top_mask(input logic [CW-1:0] n);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) begin
      m[W-1-i] = (CW'(i) < n);
    end
    return m;
  endfunction

  // Zero the data bytes whose keep bit is clear.
  function automatic logic [DATA_WD-1:0] mask_bytes(input logic [DATA_WD-1:0] d,
                                                    input logic [W-1:0]       k);
    logic [DATA_WD-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
    end
    return r;
  endfunction

  assign adv_s       = !valid_out_r | ready_out;
  assign hdr_fire_s  = valid_insert & ready_insert_r;
  assign ready_in    = (state_r == BODY) & adv_s;
  assign beat_fire_s = valid_in & ready_in;

  // Clamp the header length to the supported maximum.
  always_comb begin
    cnt_clamp_s = {CW{1'b0}};
    if (byte_insert_cnt > HDR_CNT_WD'(MAX_HDR_BYTES)) begin
      cnt_clamp_s = CW'(MAX_HDR_BYTES);
    end else begin
      cnt_clamp_s = CW'(byte_insert_cnt);
    end
  end

  // Left-align the incoming header. Bytes above the count are shifted out.
  assign ins_shift_s = CW'(MAX_HDR_BYTES) - cnt_clamp_s;
  assign ins_align_s = {data_insert, {(8*W){1'b0}}} << {ins_shift_s, 3'b000};

  // In IDLE, the header comes straight from the inputs. This lets the first
  // header beat be emitted in the same cycle as the handshake.
  always_comb begin
    hsrc_s = hdr_r;
    hlen_s = hdr_len_r;
    if (state_r == IDLE) begin
      hsrc_s = ins_align_s;
      hlen_s = cnt_clamp_s;
    end else begin
      hsrc_s = hdr_r;
      hlen_s = hdr_len_r;
    end
  end

  assign hbeat_s    = hsrc_s[HBW-1 -: DATA_WD];
  assign hshift_s   = {hsrc_s[HBW-8*W-1:0], {(8*W){1'b0}}};
  assign hrem_s     = hlen_s - CW'(W);
  assign hdr_step_s = adv_s & (((state_r == IDLE) & hdr_fire_s & (hlen_s >= CW'(W)))
                               | (state_r == HDR));

  // Byte stream in BODY: the residual bytes, then the masked payload bytes.
  assign pay_s  = mask_bytes(data_in, keep_in);
  assign k_s    = popcount(keep_in);
  assign t_s    = res_cnt_r + k_s;
  assign comb_s = {res_r, {DATA_WD{1'b0}}}
                | ({pay_s, {DATA_WD{1'b0}}} >> {res_cnt_r, 3'b000});

  // Insertion FSM, residual buffer, registered output stage and packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      hdr_r          <= {HBW{1'b0}};
      hdr_len_r      <= {CW{1'b0}};
      res_r          <= {DATA_WD{1'b0}};
      res_cnt_r      <= {CW{1'b0}};
      valid_out_r    <= 1'b0;
      data_out_r     <= {DATA_WD{1'b0}};
      keep_out_r     <= {W{1'b0}};
      last_out_r     <= 1'b0;
      ready_insert_r <= 1'b0;
      pkt_cnt_r      <= 32'd0;
    end else begin
      if (valid_out_r && ready_out && last_out_r) begin
        pkt_cnt_r <= pkt_cnt_r + 32'd1;
      end
      // Any beat that is not reloaded below drains when the stage can advance.
      if (adv_s) begin
        valid_out_r <= 1'b0;
      end

      if (hdr_step_s) begin
        valid_out_r    <= 1'b1;
        data_out_r     <= hbeat_s;
        keep_out_r     <= {W{1'b1}};
        last_out_r     <= 1'b0;
        ready_insert_r <= 1'b0;
        if (hrem_s < CW'(W)) begin
          res_r     <= hshift_s[HBW-1 -: DATA_WD];
          res_cnt_r <= hrem_s;
          state_r   <= BODY;
        end else begin
          hdr_r     <= hshift_s;
          hdr_len_r <= hrem_s;
          state_r   <= HDR;
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (hdr_fire_s) begin
              ready_insert_r <= 1'b0;
              if (hlen_s < CW'(W)) begin
                // A short header goes straight into the residual buffer.
                res_r     <= hbeat_s;
                res_cnt_r <= hlen_s;
                state_r   <= BODY;
              end else begin
                hdr_r     <= hsrc_s;
                hdr_len_r <= hlen_s;
                state_r   <= HDR;
              end
            end else begin
              ready_insert_r <= 1'b1;
            end
          end
          HDR: begin
            state_r <= HDR;
          end
          BODY: begin
            if (beat_fire_s) begin
              valid_out_r <= 1'b1;
              data_out_r  <= comb_s[2*DATA_WD-1 -: DATA_WD];
              if (!last_in) begin
                keep_out_r <= {W{1'b1}};
                last_out_r <= 1'b0;
                res_r      <= comb_s[DATA_WD-1:0];
                res_cnt_r  <= t_s - CW'(W);
              end else if (t_s <= CW'(W)) begin
                keep_out_r     <= top_mask(t_s);
                last_out_r     <= 1'b1;
                res_r          <= {DATA_WD{1'b0}};
                res_cnt_r      <= {CW{1'b0}};
                ready_insert_r <= 1'b1;
                state_r        <= IDLE;
              end else begin
                keep_out_r <= {W{1'b1}};
                last_out_r <= 1'b0;
                res_r      <= comb_s[DATA_WD-1:0];
                res_cnt_r  <= t_s - CW'(W);
                state_r    <= TAIL;
              end
            end
          end
          TAIL: begin
            if (adv_s) begin
              valid_out_r    <= 1'b1;
              data_out_r     <= res_r;
              keep_out_r     <= top_mask(res_cnt_r);
              last_out_r     <= 1'b1;
              res_r          <= {DATA_WD{1'b0}};
              res_cnt_r      <= {CW{1'b0}};
              ready_insert_r <= 1'b1;
              state_r        <= IDLE;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign valid_out    = valid_out_r;
  assign data_out     = data_out_r;
  assign keep_out     = keep_out_r;
  assign last_out     = last_out_r;
  assign ready_insert = ready_insert_r;
  assign pkt_cnt      = pkt_cnt_r;

endmodule

// File: tb/tb_axi_stream_insert_header_wide.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_insert_header_wide
// Directed and randomised checks for axi_stream_insert_header_wide, using
// DATA_WD=32 and MAX_HDR_BYTES=16. Expected beats are either hand-computed
// or taken from a byte-queue model of the header and payload streams.
// -----------------------------------------------------------------------------
module tb_axi_stream_insert_header_wide;

  logic         clk;
  logic         rst_n;
  logic         valid_in;
  logic [31:0]  data_in;
  logic [3:0]   keep_in;
  logic         last_in;
  logic         ready_in;
  logic         valid_insert;
  logic [127:0] data_insert;
  logic [4:0]   byte_insert_cnt;
  logic         ready_insert;
  logic         valid_out;
  logic [31:0]  data_out;
  logic [3:0]   keep_out;
  logic         last_out;
  logic         ready_out;
  logic [31:0]  pkt_cnt;

  int tests = 0;
  int fails = 0;

  logic [36:0] cap_q[$];   // captured output beats {data, keep, last}
  logic [7:0]  exp_q[$];   // model byte stream
  int          len_q[$];   // model packet lengths
  int          cur_rem, out_pkts, pk_gen, phase, beats_left, last_n, hraw, hlen, nbeats;
  logic        hf, bf;
  logic [36:0] obs, expv;
  logic [31:0] ed;

  axi_stream_insert_header_wide dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_insert(valid_insert), .data_insert(data_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out), .pkt_cnt(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted output beat.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_out) cap_q.push_back({data_out, keep_out, last_out});
  end

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] kmask(input int n);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[3-i] = (i < n);
    return m;
  endfunction

  task automatic send_hdr(input logic [4:0] cnt, input logic [127:0] d);
    logic ok;
    ok = 1'b0;
    valid_insert = 1'b1; byte_insert_cnt = cnt; data_insert = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = ready_insert;
      step();
    end
    valid_insert = 1'b0;
    check("hdr_accept", ok, 1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic ok;
    ok = 1'b0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = ready_in;
      step();
    end
    valid_in = 1'b0;
    check("beat_accept", ok, 1);
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                             input logic l);
    logic [36:0] o;
    o = 'x;
    if (cap_q.size() > 0) o = cap_q.pop_front();
    check(tag, o, {d, k, l});
  endtask

  task automatic new_packet();
    hraw = $urandom_range(0, 20);
    hlen = (hraw > 16) ? 16 : hraw;
    data_insert = {$urandom, $urandom, $urandom, $urandom};
    byte_insert_cnt = hraw[4:0];
    for (int i = 0; i < hlen; i++) exp_q.push_back(data_insert[8*(hlen-1-i) +: 8]);
    nbeats = $urandom_range(1, 4);
    last_n = $urandom_range(1, 4);
    len_q.push_back(hlen + (nbeats - 1) * 4 + last_n);
    phase = 0;
  endtask

  task automatic new_beat();
    int n;
    data_in = $urandom;
    n = (beats_left == 1) ? last_n : 4;
    keep_in = kmask(n);
    last_in = (beats_left == 1);
    for (int i = 0; i < n; i++) exp_q.push_back(data_in[31-8*i -: 8]);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; data_in = 32'h0; keep_in = 4'h0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = 128'h0; byte_insert_cnt = 5'd0; ready_out = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_outs", {valid_out, data_out, keep_out, last_out, ready_in, ready_insert}, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    rst_n = 1'b1;
    step();
    check("rdy_insert_after_rst", ready_insert, 1);

    // 3-byte header: 11 bytes total, so the tail carries 3 bytes
    send_hdr(5'd3, 128'hAABBCC);
    send_beat(32'h01020304, 4'hF, 1'b0);
    send_beat(32'h05060708, 4'hF, 1'b1);
    repeat (6) step();
    expect_beat("s1_b0", 32'hAABBCC01, 4'hF, 1'b0);
    expect_beat("s1_b1", 32'h02030405, 4'hF, 1'b0);
    expect_beat("s1_b2", 32'h06070800, 4'hE, 1'b1);
    check("s1_count", cap_q.size(), 0);

    // No header: pass-through with one cycle latency
    send_hdr(5'd0, 128'h0);
    send_beat(32'h01020304, 4'hF, 1'b0);
    check("s2_latency", {valid_out, data_out}, {1'b1, 32'h01020304});
    send_beat(32'h05060708, 4'hC, 1'b1);
    repeat (6) step();
    expect_beat("s2_b0", 32'h01020304, 4'hF, 1'b0);
    expect_beat("s2_b1", 32'h05060000, 4'hC, 1'b1);
    check("s2_count", cap_q.size(), 0);

    // 6-byte header with ready_out held low for 3 cycles
    ready_out = 1'b0;
    send_hdr(5'd6, 128'h111213141516);
    valid_in = 1'b1; data_in = 32'hA1A2A3A4; keep_in = 4'hE; last_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("s3_stall", {valid_out, data_out, keep_out, last_out, ready_in},
            {1'b1, 32'h11121314, 4'hF, 1'b0, 1'b0});
    end
    step();
    ready_out = 1'b1;
    send_beat(32'hA1A2A3A4, 4'hE, 1'b1);
    repeat (6) step();
    expect_beat("s3_b0", 32'h11121314, 4'hF, 1'b0);
    expect_beat("s3_b1", 32'h1516A1A2, 4'hF, 1'b0);
    expect_beat("s3_b2", 32'hA3000000, 4'h8, 1'b1);
    check("s3_count", cap_q.size(), 0);

    // 1-byte header fills a single beat exactly
    send_hdr(5'd1, 128'h55);
    send_beat(32'hA1A2A3A4, 4'hE, 1'b1);
    repeat (6) step();
    expect_beat("s4_single", 32'h55A1A2A3, 4'hF, 1'b1);

    // Max header (16) and a clamped count (20) give the same packet
    for (int c = 16; c <= 20; c += 4) begin
      send_hdr(5'(c), 128'h00112233445566778899AABBCCDDEEFF);
      send_beat(32'hA1A2A3A4, 4'hE, 1'b1);
      repeat (8) step();
      expect_beat("s4_h0", 32'h00112233, 4'hF, 1'b0);
      expect_beat("s4_h1", 32'h44556677, 4'hF, 1'b0);
      expect_beat("s4_h2", 32'h8899AABB, 4'hF, 1'b0);
      expect_beat("s4_h3", 32'hCCDDEEFF, 4'hF, 1'b0);
      expect_beat("s4_pl", 32'hA1A2A300, 4'hE, 1'b1);
      check("s4_count", cap_q.size(), 0);
    end
    check("pkt_cnt_dir", pkt_cnt, 6);

    // Asynchronous reset in the middle of a packet
    send_hdr(5'd3, 128'hAABBCC);
    send_beat(32'h01020304, 4'hF, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("s6_rst_outs", {valid_out, data_out, keep_out, last_out, ready_in, ready_insert}, 0);
    check("s6_rst_pkt", pkt_cnt, 0);
    #2 rst_n = 1'b1;
    cap_q.delete();
    step();
    check("s6_rdy_insert", ready_insert, 1);
    send_hdr(5'd3, 128'hAABBCC);
    send_beat(32'h01020304, 4'hF, 1'b0);
    send_beat(32'h05060708, 4'hF, 1'b1);
    repeat (6) step();
    expect_beat("s6_b0", 32'hAABBCC01, 4'hF, 1'b0);
    expect_beat("s6_b1", 32'h02030405, 4'hF, 1'b0);
    expect_beat("s6_b2", 32'h06070800, 4'hE, 1'b1);
    check("s6_pkt_cnt", pkt_cnt, 1);

    // Random traffic against the byte-queue model
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    cap_q.delete();
    cur_rem = 0; out_pkts = 0; pk_gen = 0; hf = 1'b0; bf = 1'b0;
    new_packet();
    for (int cyc = 0; cyc < 60000 && out_pkts < 1000; cyc++) begin
      step();
      if (hf) begin
        phase = 1; beats_left = nbeats; new_beat();
      end else if (bf) begin
        beats_left--;
        if (beats_left == 0) begin
          pk_gen++;
          if (pk_gen < 1000) new_packet(); else phase = 2;
        end else begin
          new_beat();
        end
      end
      while (cap_q.size() > 0) begin
        int n;
        obs = cap_q.pop_front();
        if (cur_rem == 0 && len_q.size() > 0) cur_rem = len_q.pop_front();
        n = (cur_rem > 4) ? 4 : cur_rem;
        ed = 32'h0;
        for (int i = 0; i < n; i++) if (exp_q.size() > 0) ed[31-8*i -: 8] = exp_q.pop_front();
        expv = {ed, kmask(n), (cur_rem <= 4)};
        if (cur_rem <= 4) out_pkts++;
        cur_rem -= n;
        check("rand_beat", obs, expv);
      end
      valid_insert = (phase == 0) && ($urandom_range(0, 3) != 0);
      valid_in     = (phase == 1) && ($urandom_range(0, 3) != 0);
      ready_out    = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hf = valid_insert && ready_insert;
      bf = valid_in && ready_in;
    end
    step();
    valid_insert = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    check("rand_done", out_pkts, 1000);
    check("rand_pkt_cnt", pkt_cnt, 1000);
    check("rand_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
